cnn_sched: RTL

CNN_SCHED -- requirements
Module: cnn_sched

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/sat_cnt.sv | 32 +++
 rtl/cnn_sched.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared types and default constants for the conv-2 frame scheduler.
package cnn_pkg;

   // Scheduler FSM states.
   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      DRAIN,
      DONE
   } sched_state_t;

   localparam int N_POS_DEF  = 100;
   localparam int N_WORD_DEF = 100;
   localparam int WD_MAX_DEF = 31;

   localparam int POS_W  = 7;
   localparam int WORD_W = 10;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at MAX once reached.
module sat_cnt #(
   parameter int W   = 10,
   parameter int MAX = 1023
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;
   logic         w_at_max;

   assign w_at_max = (r_cnt == W'(MAX));

   // Count register: reset and clear win over increment; stop at MAX.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !w_at_max) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/cnn_sched.sv
// Conv-2 frame scheduler: issues one start per position, waits on the
// datapath, drains pooled output words and closes the frame with tx_done.
module cnn_sched
   import cnn_pkg::*;
#(
   parameter int N_POS  = N_POS_DEF,
   parameter int N_WORD = N_WORD_DEF,
   parameter int WD_MAX = WD_MAX_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frm_strt,
   input  logic       abort,
   input  logic       src_vld,
   input  logic       l2_bsy,
   input  logic       word_vld,
   output logic       strt,
   output logic       src_ack,
   output logic       tx_done,
   output logic       busy,
   output logic [6:0] pos_cnt,
   output logic       err
);

   localparam int WD_W = $clog2(WD_MAX + 1);

   sched_state_t      r_state;
   sched_state_t      w_nxt;
   logic [POS_W-1:0]  r_pos;
   logic              r_busy;
   logic              r_err;

   logic [WORD_W-1:0] w_word_cnt;
   logic [WD_W-1:0]   w_wd_cnt;

   logic w_accept;
   logic w_issue;
   logic w_done;
   logic w_in_frame;
   logic w_word_en;
   logic w_word_full;
   logic w_word_ovf;
   logic w_drain_ok;
   logic w_wd_expire;
   logic w_err_set;

   assign w_accept    = (r_state == IDLE) && frm_strt;
   assign w_in_frame  = (r_state == ISSUE) || (r_state == WAIT) || (r_state == DRAIN);
   assign w_word_en   = w_in_frame && word_vld;
   assign w_word_full = (w_word_cnt == WORD_W'(N_WORD));
   assign w_word_ovf  = w_word_en && w_word_full;
   // The final word arriving in this very cycle already completes the frame.
   assign w_drain_ok  = w_word_full || (word_vld && (w_word_cnt == WORD_W'(N_WORD - 1)));
   // Expiry happens on the WD_MAX-th WAIT cycle if the datapath is still busy.
   assign w_wd_expire = (r_state == WAIT) && l2_bsy && (w_wd_cnt == WD_W'(WD_MAX - 1));
   assign w_err_set   = (w_wd_expire && !abort) || w_word_ovf;

   // Pooled output words consumed during the active part of the frame.
   sat_cnt #(
      .W   (WORD_W),
      .MAX (N_WORD)
   ) u_word_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (w_accept),
      .i_inc (w_word_en),
      .o_cnt (w_word_cnt)
   );

   // Cycles spent in WAIT for the current position; zero marks the first one.
   sat_cnt #(
      .W   (WD_W),
      .MAX (WD_MAX)
   ) u_wd_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (r_state != WAIT),
      .i_inc (r_state == WAIT),
      .o_cnt (w_wd_cnt)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nxt;
      end
   end

   // Next-state and pulse decode; abort overrides every other exit.
   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_nxt   = r_state;
      w_issue = 1'b0;
      w_done  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (frm_strt) w_nxt = ISSUE;
         end
         ISSUE: begin
            if (abort) begin
               w_nxt = DONE;
            end else if (src_vld && !l2_bsy) begin
               w_issue = 1'b1;
               w_nxt   = WAIT;
            end
         end
         WAIT: begin
            if (abort || w_wd_expire) begin
               w_nxt = DONE;
            end else if ((w_wd_cnt != '0) && !l2_bsy) begin
               w_nxt = (r_pos == POS_W'(N_POS)) ? DRAIN : ISSUE;
            end
         end
         DRAIN: begin
            if (abort || w_drain_ok) w_nxt = DONE;
         end
         DONE: begin
            w_done = 1'b1;
            w_nxt  = IDLE;
         end
         default: w_nxt = IDLE;
      endcase
   end

   // Position count: cleared on frame accept, bumped on each start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pos <= '0;
      end else if (w_accept) begin
         r_pos <= '0;
      end else if (w_issue) begin
         r_pos <= r_pos + POS_W'(1);
      end
   end

   // Busy spans frame accept through the tx_done cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
      end else if (w_accept) begin
         r_busy <= 1'b1;
      end else if (r_state == DONE) begin
         r_busy <= 1'b0;
      end
   end

   // Sticky error, cleared only when a new frame is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= 1'b0;
      end else if (w_err_set) begin
         r_err <= 1'b1;
      end
   end

   assign strt    = w_issue;
   assign src_ack = w_issue;
   assign tx_done = w_done;
   assign busy    = r_busy;
   assign pos_cnt = r_pos;
   assign err     = r_err;

endmodule
